// File: rtl/led_cmd_ctrl_pkg.sv
// led_cmd_ctrl_pkg: shared command codes, chip-select levels, FSM states and brightness clamp.
package led_cmd_ctrl_pkg;
    localparam logic       CS_ASSERT          = 1'b0;
    localparam logic       CS_DEASSERT        = 1'b1;
    localparam int         MASTER_FRAME_WIDTH = 24;
    localparam logic [7:0] CMD_NOP            = 8'h00;
    localparam logic [7:0] CMD_WRITE          = 8'h01;
    localparam logic [7:0] CMD_READ           = 8'h02;
    localparam logic [7:0] CMD_ERR            = 8'hEE;
    localparam logic [7:0] BRIGHT_MAX         = 8'd100;
    localparam int         PWM_STEPS          = 100;

    typedef enum logic [2:0] {
        ST_IDLE, ST_DECODE, ST_EXEC, ST_RESP, ST_ERR, ST_WAIT_CS
    } state_t;

    function automatic logic [7:0] sat_bright(input logic [7:0] v);
        return (v > BRIGHT_MAX) ? BRIGHT_MAX : v;
    endfunction
endpackage

// File: rtl/led_cmd_ctrl_pwm.sv
// led_pwm: shared prescaler and 0..99 step counter driving N_LEDS registered PWM outputs.
module led_pwm
    import led_cmd_ctrl_pkg::*;
#(
    parameter int N_LEDS   = 4,
    parameter int PRESCALE = 125
) (
    input  logic                   sysclk,
    input  logic                   rst_n,
    input  logic [N_LEDS-1:0][7:0] i_bright,
    output logic [N_LEDS-1:0]      o_led
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]          r_pre;
    logic [6:0]             r_step;
    logic [N_LEDS-1:0][7:0] r_shadow;
    logic [N_LEDS-1:0]      r_led;
    logic                   w_tick;
    logic                   w_wrap;

    assign w_tick = r_pre == PW'(PRESCALE - 1);
    assign w_wrap = w_tick && (r_step == 7'(PWM_STEPS - 1));
    assign o_led  = r_led;

    // Duty is only reloaded at the period boundary so a write never truncates a pulse.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre    <= '0;
            r_step   <= '0;
            r_shadow <= '0;
            r_led    <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) r_step <= w_wrap ? '0 : r_step + 1'b1;
            if (w_wrap) r_shadow <= i_bright;
            for (int i = 0; i < N_LEDS; i++) r_led[i] <= {1'b0, r_step} < r_shadow[i];
        end
    end
endmodule

// File: rtl/led_cmd_ctrl.sv
// led_cmd_ctrl: executes SPI write/read commands on a per-LED brightness file and
// returns the read-back frame with tx enable to the SPI slave.
module led_cmd_ctrl
    import led_cmd_ctrl_pkg::*;
#(
    parameter int N_LEDS   = 4,
    parameter int PRESCALE = 125,
    parameter int ERR_W    = 8
) (
    input  logic                          sysclk,
    input  logic                          rst_n,
    input  logic                          i_cs,
    input  logic [7:0]                    i_cmd,
    input  logic [7:0]                    i_addr,
    input  logic [7:0]                    i_payload,
    output logic                          o_slv_tx_enb,
    output logic [MASTER_FRAME_WIDTH-1:0] o_slv_frame,
    output logic [N_LEDS-1:0]             o_led,
    output logic [ERR_W-1:0]              o_err_cnt
);
    localparam int AW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    state_t                          r_state, w_next;
    logic [7:0]                      r_cmd_prev, r_cmd, r_addr, r_payload;
    logic [N_LEDS-1:0][7:0]          r_bright;
    logic [MASTER_FRAME_WIDTH-1:0]   r_frame;
    logic                            r_frame_vld, r_tx_enb;
    logic [ERR_W-1:0]                r_err_cnt;
    logic                            w_cs_on, w_trig, w_bad;
    logic [7:0]                      w_rd_bright;

    assign w_cs_on      = i_cs == CS_ASSERT;
    assign w_trig       = w_cs_on && (i_cmd != CMD_NOP) && (r_cmd_prev == CMD_NOP);
    assign w_bad        = (r_addr >= 8'(N_LEDS)) || ((r_cmd != CMD_WRITE) && (r_cmd != CMD_READ));
    assign w_rd_bright  = r_bright[r_addr[AW-1:0]];
    assign o_slv_tx_enb = r_tx_enb;
    assign o_slv_frame  = r_frame;
    assign o_err_cnt    = r_err_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:                  w_next = w_trig ? ST_DECODE : ST_IDLE;
            ST_DECODE:                w_next = w_bad ? ST_ERR : ((r_cmd == CMD_WRITE) ? ST_EXEC : ST_RESP);
            ST_EXEC, ST_RESP, ST_ERR: w_next = ST_WAIT_CS;
            ST_WAIT_CS:               w_next = ST_WAIT_CS;
            default:                  w_next = ST_IDLE;
        endcase
        // Losing chip select abandons the frame from any active state.
        if (r_state != ST_IDLE && !w_cs_on) w_next = ST_IDLE;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd_prev  <= CMD_NOP;
            r_cmd       <= CMD_NOP;
            r_addr      <= '0;
            r_payload   <= '0;
            r_bright    <= '0;
            r_frame     <= '0;
            r_frame_vld <= 1'b0;
            r_tx_enb    <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state    <= w_next;
            r_cmd_prev <= i_cmd;
            if (r_state == ST_IDLE && w_trig) begin
                r_cmd     <= i_cmd;
                r_addr    <= i_addr;
                r_payload <= i_payload;
            end
            if (r_state == ST_EXEC) r_bright[r_addr[AW-1:0]] <= sat_bright(r_payload);
            if (r_state == ST_ERR && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            if (!w_cs_on) begin
                r_frame     <= '0;
                r_frame_vld <= 1'b0;
                r_tx_enb    <= 1'b0;
            end else if (r_state == ST_RESP) begin
                r_frame     <= {CMD_READ, r_addr, w_rd_bright};
                r_frame_vld <= 1'b1;
            end else if (r_state == ST_ERR && r_cmd == CMD_READ) begin
                r_frame     <= {CMD_ERR, r_addr, 8'h00};
                r_frame_vld <= 1'b1;
            end else if (r_state == ST_WAIT_CS) begin
                r_tx_enb    <= r_frame_vld;
            end
        end
    end

    led_pwm #(.N_LEDS(N_LEDS), .PRESCALE(PRESCALE)) u_pwm (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .i_bright (r_bright),
        .o_led    (o_led)
    );
endmodule

// File: tb/tb_led_cmd_ctrl.sv
// tb_led_cmd_ctrl: scoreboard bench for led_cmd_ctrl; read frames are queued at issue
// and compared when tx enable rises, latency/duty/error checks are made inline.
module tb_led_cmd_ctrl;
    localparam int PRESC = 4;
    localparam int PER   = PRESC * 100;

    logic        sysclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        cs     = 1'b1;
    logic [7:0]  cmd    = 8'h00;
    logic [7:0]  addr   = 8'h00;
    logic [7:0]  payload = 8'h00;
    logic        tx;
    logic [23:0] frame;
    logic [3:0]  led;
    logic [7:0]  err;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [23:0] sb_q[$];
    logic [7:0]  m_bright[4] = '{default: 8'h00};
    int          m_err  = 0;
    logic        prev_tx = 1'b0;

    led_cmd_ctrl #(.N_LEDS(4), .PRESCALE(PRESC), .ERR_W(8)) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .i_cs         (cs),
        .i_cmd        (cmd),
        .i_addr       (addr),
        .i_payload    (payload),
        .o_slv_tx_enb (tx),
        .o_slv_frame  (frame),
        .o_led        (led),
        .o_err_cnt    (err)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge sysclk) begin
        if (rst_n && tx && !prev_tx) begin
            if (sb_q.size() == 0) chk("sb_unexpected_tx", 32'd1, 32'd0);
            else chk("sb_frame", {8'h00, frame}, {8'h00, sb_q.pop_front()});
        end
        prev_tx = tx;
    end

    task automatic xfer(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
        logic       rd, wr, bad;
        logic [7:0] old;
        rd  = c == 8'h02;
        bad = (a >= 8'd4) || (c != 8'h01 && c != 8'h02);
        wr  = (c == 8'h01) && !bad;
        old = bad ? 8'h00 : m_bright[a[1:0]];
        @(negedge sysclk);
        cs = 1'b0; cmd = c; addr = a; payload = p;
        if (wr) m_bright[a[1:0]] = (p > 8'd100) ? 8'd100 : p;
        if (bad && m_err < 255) m_err++;
        if (rd) sb_q.push_back(bad ? {8'hEE, a, 8'h00} : {8'h02, a, m_bright[a[1:0]]});
        repeat (2) @(negedge sysclk);
        if (wr) chk("wr_t1_old", {24'h0, dut.r_bright[a[1:0]]}, {24'h0, old});
        @(negedge sysclk);
        if (wr) chk("wr_t2_new", {24'h0, dut.r_bright[a[1:0]]}, {24'h0, m_bright[a[1:0]]});
        if (rd) chk("tx_t2_low", {31'h0, tx}, 32'd0);
        @(negedge sysclk);
        chk("tx_t3", {31'h0, tx}, {31'h0, rd});
        chk("err_cnt", {24'h0, err}, m_err);
        repeat (3) @(negedge sysclk);
        if (rd) chk("tx_hold", {31'h0, tx}, 32'd1);
        cs = 1'b1; cmd = 8'h00;
        @(negedge sysclk);
        chk("tx_clr", {31'h0, tx}, 32'd0);
        chk("frame_clr", {8'h0, frame}, 32'd0);
    endtask

    task automatic duty(input int ch, input int exp_high);
        int h;
        h = 0;
        repeat (2 * PER) @(negedge sysclk);
        for (int k = 0; k < PER; k++) begin
            @(negedge sysclk);
            h += int'(led[ch]);
        end
        chk($sformatf("duty_led%0d", ch), h, exp_high);
    endtask

    initial begin
        repeat (3) @(negedge sysclk);
        chk("rst_tx", {31'h0, tx}, 32'd0);
        chk("rst_frame", {8'h0, frame}, 32'd0);
        chk("rst_led", {28'h0, led}, 32'd0);
        chk("rst_err", {24'h0, err}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);

        xfer(8'h01, 8'd2, 8'd50);
        duty(2, 50 * PRESC);
        xfer(8'h01, 8'd1, 8'd200);
        duty(1, PER);
        xfer(8'h01, 8'd1, 8'd0);
        duty(1, 0);
        xfer(8'h02, 8'd2, 8'h00);

        xfer(8'h01, 8'd7, 8'd9);
        chk("bad_wr_noop", dut.r_bright, {m_bright[3], m_bright[2], m_bright[1], m_bright[0]});
        xfer(8'h02, 8'd9, 8'h00);
        xfer(8'h05, 8'd0, 8'h00);

        // command held across one CS frame must act once
        @(negedge sysclk);
        cs = 1'b0; cmd = 8'h01; addr = 8'd0; payload = 8'd10;
        m_bright[0] = 8'd10;
        repeat (4) @(negedge sysclk);
        payload = 8'd20;
        repeat (6) @(negedge sysclk);
        chk("held_single", {24'h0, dut.r_bright[0]}, 32'd10);
        cs = 1'b1; cmd = 8'h00;
        xfer(8'h02, 8'd0, 8'h00);

        // CS dropped right after the read trigger
        @(negedge sysclk);
        cs = 1'b0; cmd = 8'h02; addr = 8'd2;
        @(negedge sysclk);
        cs = 1'b1; cmd = 8'h00;
        for (int k = 0; k < 5; k++) begin
            @(negedge sysclk);
            chk("drop_tx", {31'h0, tx}, 32'd0);
        end
        xfer(8'h02, 8'd2, 8'h00);

        xfer(8'h01, 8'd1, 8'd100);
        repeat (2 * PER) @(negedge sysclk);
        chk("pre_rst_led1", {31'h0, led[1]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", {28'h0, led}, 32'd0);
        chk("async_rst_tx", {31'h0, tx}, 32'd0);
        chk("async_rst_err", {24'h0, err}, 32'd0);
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
